// File: rtl/stage_id_pipe.sv
// rtl/stage_id_pipe.sv - Decode stage with ID/EX register, load-use stall, operand forwarding and flush
// Define STAGE_ID_FWD_EN for EX/MEM forwarding; without it any EX/MEM source match stalls decode.
module stage_id_pipe #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_valid,
   input  logic [31:0]       if_inst,
   input  logic [DATA_W-1:0] if_pc,
   output logic              id_ready,
   output logic [4:0]        rf_rs_addr,
   output logic [4:0]        rf_rt_addr,
   input  logic [DATA_W-1:0] rf_rs_data,
   input  logic [DATA_W-1:0] rf_rt_data,
   input  logic              ex_ready,
   input  logic              flush,
   input  logic              ex_wr_en,
   input  logic              ex_is_load,
   input  logic [4:0]        ex_wr_addr,
   input  logic [DATA_W-1:0] ex_wr_data,
   input  logic              mem_wr_en,
   input  logic [4:0]        mem_wr_addr,
   input  logic [DATA_W-1:0] mem_wr_data,
   output logic              id_valid,
   output logic [31:0]       id_inst,
   output logic [DATA_W-1:0] id_pc,
   output logic [DATA_W-1:0] id_rega,
   output logic [DATA_W-1:0] id_regb,
   output logic [DATA_W-1:0] id_imm,
   output logic [CNT_W-1:0]  stall_count
);

   localparam logic [5:0] OP_ANDI = 6'h0C;
   localparam logic [5:0] OP_ORI  = 6'h0D;
   localparam logic [5:0] OP_XORI = 6'h0E;

   logic [5:0]        op;
   logic [4:0]        rs;
   logic [4:0]        rt;
   logic              ex_rs_hit;
   logic              ex_rt_hit;
   logic              mem_rs_hit;
   logic              mem_rt_hit;
   logic              hazard_stall;
   logic [DATA_W-1:0] rega_next;
   logic [DATA_W-1:0] regb_next;
   logic [DATA_W-1:0] imm_next;

   assign op         = if_inst[31:26];
   assign rs         = if_inst[25:21];
   assign rt         = if_inst[20:16];
   assign rf_rs_addr = rs;
   assign rf_rt_addr = rt;

   // A write to $0 never matches, so $0 always reads register-file data.
   assign ex_rs_hit  = ex_wr_en  && (ex_wr_addr  != 5'd0) && (ex_wr_addr  == rs);
   assign ex_rt_hit  = ex_wr_en  && (ex_wr_addr  != 5'd0) && (ex_wr_addr  == rt);
   assign mem_rs_hit = mem_wr_en && (mem_wr_addr != 5'd0) && (mem_wr_addr == rs);
   assign mem_rt_hit = mem_wr_en && (mem_wr_addr != 5'd0) && (mem_wr_addr == rt);

   always_comb begin
      imm_next = DATA_W'($signed(if_inst[15:0]));
      if (op == OP_ANDI || op == OP_ORI || op == OP_XORI)
         imm_next = DATA_W'(if_inst[15:0]);
   end

`ifdef STAGE_ID_FWD_EN
   assign hazard_stall = if_valid & ex_is_load & (ex_rs_hit | ex_rt_hit);

   // EX result is younger than MEM, so it wins; a load in EX has no data yet.
   assign rega_next = (ex_rs_hit && !ex_is_load) ? ex_wr_data  :
                      mem_rs_hit                 ? mem_wr_data : rf_rs_data;
   assign regb_next = (ex_rt_hit && !ex_is_load) ? ex_wr_data  :
                      mem_rt_hit                 ? mem_wr_data : rf_rt_data;
`else
   logic unused_fwd;

   assign hazard_stall = if_valid & (ex_rs_hit | ex_rt_hit | mem_rs_hit | mem_rt_hit);
   assign rega_next    = rf_rs_data;
   assign regb_next    = rf_rt_data;
   assign unused_fwd   = ^{ex_is_load, ex_wr_data, mem_wr_data};
`endif

   assign id_ready = ex_ready & ~hazard_stall;

   always_ff @(posedge clock) begin
      if (!reset) begin
         id_valid    <= 1'b0;
         id_inst     <= '0;
         id_pc       <= '0;
         id_rega     <= '0;
         id_regb     <= '0;
         id_imm      <= '0;
         stall_count <= '0;
      end else begin
         if (flush) begin
            id_valid <= 1'b0;
         end else if (ex_ready) begin
            if (hazard_stall) begin
               id_valid <= 1'b0;
               id_inst  <= '0;
            end else begin
               id_valid <= if_valid;
               id_inst  <= if_inst;
               id_pc    <= if_pc;
               id_rega  <= rega_next;
               id_regb  <= regb_next;
               id_imm   <= imm_next;
            end
         end
         if (hazard_stall && !flush && (stall_count != {CNT_W{1'b1}}))
            stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_stage_id_pipe.sv
// tb/tb_stage_id_pipe.sv - Vector table, directed sequences and random run against a rule-level model
module tb_stage_id_pipe;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 5;
   localparam int MAXC   = (1 << CNT_W) - 1;
`ifdef STAGE_ID_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   localparam logic [31:0] I_ADDI = 32'h2022FFFC;   // ADDI $2,$1,-4
   localparam logic [31:0] I_ORI  = 32'h34038000;   // ORI  $3,$0,0x8000
   localparam logic [31:0] I_ADD5 = 32'h00A53020;   // ADD  $6,$5,$5
   localparam logic [31:0] I_USE7 = 32'h00E04020;   // ADD  $8,$7,$0

   logic              clock = 1'b0;
   logic              reset;
   logic              if_valid;
   logic [31:0]       if_inst;
   logic [DATA_W-1:0] if_pc;
   logic              id_ready;
   logic [4:0]        rf_rs_addr;
   logic [4:0]        rf_rt_addr;
   logic [DATA_W-1:0] rf_rs_data;
   logic [DATA_W-1:0] rf_rt_data;
   logic              ex_ready;
   logic              flush;
   logic              ex_wr_en;
   logic              ex_is_load;
   logic [4:0]        ex_wr_addr;
   logic [DATA_W-1:0] ex_wr_data;
   logic              mem_wr_en;
   logic [4:0]        mem_wr_addr;
   logic [DATA_W-1:0] mem_wr_data;
   logic              id_valid;
   logic [31:0]       id_inst;
   logic [DATA_W-1:0] id_pc;
   logic [DATA_W-1:0] id_rega;
   logic [DATA_W-1:0] id_regb;
   logic [DATA_W-1:0] id_imm;
   logic [CNT_W-1:0]  stall_count;

   always #5 clock = ~clock;

   stage_id_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
      .id_ready(id_ready), .rf_rs_addr(rf_rs_addr), .rf_rt_addr(rf_rt_addr),
      .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data), .ex_ready(ex_ready), .flush(flush),
      .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_rega(id_rega), .id_regb(id_regb),
      .id_imm(id_imm), .stall_count(stall_count)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic        m_valid;
   logic [31:0] m_inst, m_pc, m_rega, m_regb, m_imm;
   int          m_stall;

   typedef struct {
      logic        rst, iv;
      logic [31:0] inst, rsd, rtd;
      logic        exr, fl, exwe, exld;
      logic [4:0]  exwa;
      logic [31:0] exwd;
      logic        mwe;
      logic [4:0]  mwa;
      logic [31:0] mwd;
      logic        e_ready, e_valid;
      logic [31:0] e_inst, e_rega, e_regb, e_imm;
      int          e_stall;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, got, want);
      end
   endtask

   function automatic bit hit(input logic en, input logic [4:0] wa, input logic [4:0] ra);
      return en && (wa != 5'd0) && (wa == ra);
   endfunction

   function automatic bit model_hazard();
      logic [4:0] src[2];
      bit ex_any  = 1'b0;
      bit mem_any = 1'b0;
      src[0] = if_inst[25:21];
      src[1] = if_inst[20:16];
      foreach (src[i]) begin
         ex_any  |= hit(ex_wr_en, ex_wr_addr, src[i]);
         mem_any |= hit(mem_wr_en, mem_wr_addr, src[i]);
      end
      if (!if_valid) return 1'b0;
      return FWD ? (ex_is_load && ex_any) : (ex_any || mem_any);
   endfunction

   function automatic logic [31:0] model_operand(input logic [4:0] ra, input logic [31:0] rf);
      if (FWD && hit(ex_wr_en, ex_wr_addr, ra) && !ex_is_load) return ex_wr_data;
      if (FWD && hit(mem_wr_en, mem_wr_addr, ra)) return mem_wr_data;
      return rf;
   endfunction

   function automatic logic [31:0] model_imm(input logic [31:0] inst);
      int unsigned v = inst[15:0];
      if (!(inst[31:26] inside {6'h0C, 6'h0D, 6'h0E}) && v >= 32768) v = v + 32'hFFFF0000;
      return v;
   endfunction

   task automatic model_clock();
      bit haz = model_hazard();
      if (!reset) begin
         m_valid = 1'b0; m_inst = '0; m_pc = '0; m_rega = '0; m_regb = '0; m_imm = '0; m_stall = 0;
      end else begin
         if (flush) m_valid = 1'b0;
         else if (ex_ready && haz) begin
            m_valid = 1'b0;
            m_inst  = '0;
         end else if (ex_ready) begin
            m_valid = if_valid;
            m_inst  = if_inst;
            m_pc    = if_pc;
            m_rega  = model_operand(if_inst[25:21], rf_rs_data);
            m_regb  = model_operand(if_inst[20:16], rf_rt_data);
            m_imm   = model_imm(if_inst);
         end
         if (haz && !flush && m_stall < MAXC) m_stall++;
      end
   endtask

   // One clock: combinational checks before the edge, registered checks just after it.
   task automatic step();
      #1;
      check("model id_ready", {31'd0, id_ready}, {31'd0, ex_ready & ~model_hazard()});
      check("model rf_rs_addr", {27'd0, rf_rs_addr}, {27'd0, if_inst[25:21]});
      check("model rf_rt_addr", {27'd0, rf_rt_addr}, {27'd0, if_inst[20:16]});
      @(posedge clock);
      model_clock();
      #1;
      check("model id_valid", {31'd0, id_valid}, {31'd0, m_valid});
      check("model id_inst", id_inst, m_inst);
      check("model id_pc", id_pc, m_pc);
      check("model id_rega", id_rega, m_rega);
      check("model id_regb", id_regb, m_regb);
      check("model id_imm", id_imm, m_imm);
      check("model stall_count", 32'(stall_count), 32'(m_stall));
   endtask

   task automatic quiet();
      reset = 1'b1; if_valid = 1'b0; if_inst = '0; if_pc = '0; rf_rs_data = '0; rf_rt_data = '0;
      ex_ready = 1'b1; flush = 1'b0; ex_wr_en = 1'b0; ex_is_load = 1'b0; ex_wr_addr = '0;
      ex_wr_data = '0; mem_wr_en = 1'b0; mem_wr_addr = '0; mem_wr_data = '0;
   endtask

   task automatic add_vec(input logic rst, iv, input logic [31:0] inst, rsd, rtd,
                          input logic exr, fl, exwe, exld, input logic [4:0] exwa,
                          input logic [31:0] exwd, input logic mwe, input logic [4:0] mwa,
                          input logic [31:0] mwd, input logic e_ready, e_valid,
                          input logic [31:0] e_inst, e_rega, e_regb, e_imm, input int e_stall);
      vec_t v;
      v.rst = rst; v.iv = iv; v.inst = inst; v.rsd = rsd; v.rtd = rtd; v.exr = exr; v.fl = fl;
      v.exwe = exwe; v.exld = exld; v.exwa = exwa; v.exwd = exwd; v.mwe = mwe; v.mwa = mwa;
      v.mwd = mwd; v.e_ready = e_ready; v.e_valid = e_valid; v.e_inst = e_inst;
      v.e_rega = e_rega; v.e_regb = e_regb; v.e_imm = e_imm; v.e_stall = e_stall;
      vecs.push_back(v);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      quiet();
      // Reset held three cycles with a valid instruction; first row has a hazard during reset.
      add_vec(0, 1, I_ADDI, 32'h1111, 32'h2222, 1, 0, 1, 1, 5'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add_vec(0, 1, I_ADDI, 32'h1111, 32'h2222, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      add_vec(0, 1, I_ADDI, 32'h1111, 32'h2222, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add_vec(1, 1, I_ADDI, 32'h1234, 32'h55, 1, 0, 0, 0, 0, 0, 0, 0, 0,
              1, 1, I_ADDI, 32'h1234, 32'h55, 32'hFFFFFFFC, 0);
      add_vec(1, 1, I_ORI, 32'h0, 32'h77, 1, 0, 1, 0, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF,
              1, 1, I_ORI, 32'h0, 32'h77, 32'h00008000, 0);
      for (int k = 0; k < 3; k++)
         add_vec(1, 1, I_ADD5, 32'h5, 32'h6, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 1, I_ORI, 32'h0, 32'h77, 32'h00008000, 0);
      add_vec(1, 1, I_USE7, 32'h70, 32'h0, 1, 1, 1, 1, 5'd7, 32'hAAAA, 0, 0, 0,
              0, 0, I_ORI, 32'h0, 32'h77, 32'h00008000, 0);
      add_vec(1, 1, I_USE7, 32'h70, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0,
              1, 1, I_USE7, 32'h70, 32'h0, 32'h4020, 0);
      add_vec(1, 1, I_USE7, 32'h70, 32'h0, 1, 0, 1, 1, 5'd7, 32'hAAAA, 0, 0, 0,
              0, 0, 32'h0, 32'h70, 32'h0, 32'h4020, 1);
      add_vec(1, 1, I_USE7, 32'h70, 32'h0, 0, 0, 1, 1, 5'd7, 32'hAAAA, 0, 0, 0,
              0, 0, 32'h0, 32'h70, 32'h0, 32'h4020, 2);
`ifdef STAGE_ID_FWD_EN
      add_vec(1, 1, I_USE7, 32'h70, 32'h0, 1, 0, 0, 0, 0, 0, 1, 5'd7, 32'h99,
              1, 1, I_USE7, 32'h99, 32'h0, 32'h4020, 2);
      add_vec(1, 1, I_ADD5, 32'h5, 32'h5, 1, 0, 1, 0, 5'd5, 32'h11, 1, 5'd5, 32'h22,
              1, 1, I_ADD5, 32'h11, 32'h11, 32'h3020, 2);
      add_vec(1, 1, I_ADD5, 32'h5, 32'h5, 1, 0, 0, 0, 0, 0, 1, 5'd5, 32'h22,
              1, 1, I_ADD5, 32'h22, 32'h22, 32'h3020, 2);
      add_vec(1, 1, I_ADD5, 32'h5, 32'h5, 1, 0, 0, 0, 0, 0, 0, 0, 0,
              1, 1, I_ADD5, 32'h5, 32'h5, 32'h3020, 2);
`else
      add_vec(1, 1, I_USE7, 32'h70, 32'h0, 1, 0, 0, 0, 0, 0, 1, 5'd7, 32'h99,
              0, 0, 32'h0, 32'h70, 32'h0, 32'h4020, 3);
      add_vec(1, 1, I_ADD5, 32'h5, 32'h5, 1, 0, 1, 0, 5'd5, 32'h11, 1, 5'd5, 32'h22,
              0, 0, 32'h0, 32'h70, 32'h0, 32'h4020, 4);
      add_vec(1, 1, I_ADD5, 32'h5, 32'h5, 1, 0, 0, 0, 0, 0, 1, 5'd5, 32'h22,
              0, 0, 32'h0, 32'h70, 32'h0, 32'h4020, 5);
      add_vec(1, 1, I_ADD5, 32'h5, 32'h5, 1, 0, 0, 0, 0, 0, 0, 0, 0,
              1, 1, I_ADD5, 32'h5, 32'h5, 32'h3020, 5);
`endif

      foreach (vecs[i]) begin
         reset = vecs[i].rst; if_valid = vecs[i].iv; if_inst = vecs[i].inst;
         if_pc = 32'h100 + 32'(4 * i); rf_rs_data = vecs[i].rsd; rf_rt_data = vecs[i].rtd;
         ex_ready = vecs[i].exr; flush = vecs[i].fl; ex_wr_en = vecs[i].exwe;
         ex_is_load = vecs[i].exld; ex_wr_addr = vecs[i].exwa; ex_wr_data = vecs[i].exwd;
         mem_wr_en = vecs[i].mwe; mem_wr_addr = vecs[i].mwa; mem_wr_data = vecs[i].mwd;
         #1;
         check($sformatf("vec%0d id_ready", i), {31'd0, id_ready}, {31'd0, vecs[i].e_ready});
         #0;
         step();
         check($sformatf("vec%0d id_valid", i), {31'd0, id_valid}, {31'd0, vecs[i].e_valid});
         check($sformatf("vec%0d id_inst", i), id_inst, vecs[i].e_inst);
         check($sformatf("vec%0d id_rega", i), id_rega, vecs[i].e_rega);
         check($sformatf("vec%0d id_regb", i), id_regb, vecs[i].e_regb);
         check($sformatf("vec%0d id_imm", i), id_imm, vecs[i].e_imm);
         check($sformatf("vec%0d stall_count", i), 32'(stall_count), 32'(vecs[i].e_stall));
      end

      // Counter saturation under a persistent load-use hazard, then flush and mid-stall reset.
      quiet();
      reset = 1'b0;
      step();
      reset = 1'b1; if_valid = 1'b1; if_inst = I_USE7; rf_rs_data = 32'h70;
      ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wr_addr = 5'd7;
      for (int k = 0; k < MAXC + 4; k++) step();
      check("sat stall_count", 32'(stall_count), MAXC);
      flush = 1'b1;
      step();
      check("sat flush stall_count", 32'(stall_count), MAXC);
      check("sat flush id_valid", {31'd0, id_valid}, 32'd0);
      flush = 1'b0; reset = 1'b0;
      step();
      check("midstall reset stall_count", 32'(stall_count), 32'd0);
      check("midstall reset id_valid", {31'd0, id_valid}, 32'd0);

      // Random traffic with small register numbers so EX/MEM matches are frequent.
      for (int n = 0; n < 3000; n++) begin
         reset       = ($urandom_range(0, 39) != 0);
         if_valid    = ($urandom_range(0, 3) != 0);
         if_inst     = $urandom;
         if_inst[31:26] = 6'($urandom_range(0, 15));
         if_inst[25:21] = 5'($urandom_range(0, 7));
         if_inst[20:16] = 5'($urandom_range(0, 7));
         if_pc       = $urandom;
         rf_rs_data  = $urandom;
         rf_rt_data  = $urandom;
         ex_ready    = ($urandom_range(0, 4) != 0);
         flush       = ($urandom_range(0, 7) == 0);
         ex_wr_en    = $urandom_range(0, 1);
         ex_is_load  = $urandom_range(0, 1);
         ex_wr_addr  = 5'($urandom_range(0, 7));
         ex_wr_data  = $urandom;
         mem_wr_en   = $urandom_range(0, 1);
         mem_wr_addr = 5'($urandom_range(0, 7));
         mem_wr_data = $urandom;
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
